// File: rtl/cv32e40p_mcy_instr_encoder.sv
// Instruction-stream source for the MCY decoder harness.
// Encodes directed field tuples into RV32 words, or produces LFSR-based random words.
// Words are queued in a small FIFO and offered to the decoder under a valid/ready handshake.
module cv32e40p_mcy_instr_encoder #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [31:0] LFSR_SEED   = 32'h0000_0001,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode_i,
  input  logic                   fld_valid_i,
  output logic                   fld_ready_o,
  input  logic [3:0]             fld_kind_i,
  input  logic [4:0]             fld_rd_i,
  input  logic [4:0]             fld_rs1_i,
  input  logic [4:0]             fld_rs2_i,
  input  logic [31:0]            fld_imm_i,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic [31:0]            instr_rdata_o,
  output logic [COUNT_WIDTH-1:0] count_o,
  input  logic                   count_clr_i,
  output logic                   kind_err_o
);

  localparam int unsigned PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [31:0] SEED_C  = (LFSR_SEED == 32'h0000_0000) ? 32'h0000_0001 : LFSR_SEED;
  localparam logic [31:0] TAPS_C  = 32'h8020_0003;

  // Returns {reserved_kind_flag, encoded_word}.
  function automatic logic [32:0] encode(input logic [3:0] kind, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [31:0] imm);
    logic [32:0] r;
    r = 33'h0_0000_0000;
    case (kind)
      4'd0:  r = {1'b0, imm[31:12], rd, 7'b0110111};
      4'd1:  r = {1'b0, imm[31:12], rd, 7'b0010111};
      4'd2:  r = {1'b0, imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      4'd3:  r = {1'b0, imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      4'd4:  r = {1'b0, imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      4'd5:  r = {1'b0, imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      4'd6:  r = {1'b0, imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      4'd7:  r = {1'b0, imm[11:0], rs1, 3'b000, rd, 7'b0010011};
      4'd8:  r = {1'b0, 7'h00, rs2, rs1, 3'b000, rd, 7'b0110011};
      4'd9:  r = {1'b0, 7'h20, rs2, rs1, 3'b000, rd, 7'b0110011};
      4'd10: r = {1'b0, 32'h0000_0073};
      4'd11: r = {1'b0, 32'h0010_0073};
      4'd12: r = {1'b0, 32'h3020_0073};
      4'd13: r = {1'b0, 32'h1050_0073};
      4'd14: r = {1'b0, 32'h0000_100F};
      default: r = {1'b1, 32'h0000_0000};
    endcase
    return r;
  endfunction

  logic [31:0]            mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]            occ_q, occ_d;
  logic                   mode_q, active_q;
  logic [31:0]            lfsr_q, lfsr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   err_q, err_d;

  logic        full_s, empty_s, mode_chg_s, dir_push_s, rnd_push_s, push_s, pop_s, hs_s;
  logic [32:0] enc_s;
  logic [31:0] push_data_s;

  // Handshake qualifiers, push data selection and output decode.
  always_comb begin
    full_s        = (occ_q == DEPTH_C);
    empty_s       = (occ_q == '0);
    mode_chg_s    = (mode_i != mode_q);
    enc_s         = encode(fld_kind_i, fld_rd_i, fld_rs1_i, fld_rs2_i, fld_imm_i);
    fld_ready_o   = active_q && !full_s && !mode_q && !mode_chg_s;
    dir_push_s    = fld_valid_i && fld_ready_o;
    rnd_push_s    = active_q && mode_q && !mode_chg_s && !full_s;
    push_s        = dir_push_s || rnd_push_s;
    push_data_s   = mode_q ? {lfsr_q[31:2], 2'b11} : enc_s[31:0];
    pop_s         = !empty_s && instr_ready_i && !mode_chg_s;
    instr_valid_o = !empty_s;
    instr_rdata_o = empty_s ? 32'h0000_0000 : mem_q[rd_ptr_q];
    hs_s          = instr_valid_o && instr_ready_i;
    count_o       = count_q;
    kind_err_o    = err_q;
  end

  // Next-state for FIFO pointers/occupancy, LFSR, counter and error flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    lfsr_d   = lfsr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (mode_chg_s) begin
      // A mode change discards everything queued under the old mode.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + PW'(1);
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + PW'(1);
      else        rd_ptr_d = rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   occ_d = occ_q + (PW+1)'(1);
        2'b01:   occ_d = occ_q - (PW+1)'(1);
        default: occ_d = occ_q;
      endcase
    end
    if (rnd_push_s) lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS_C) : (lfsr_q >> 1);
    else            lfsr_d = lfsr_q;
    if (count_clr_i)                 count_d = '0;
    else if (hs_s && (count_q != '1)) count_d = count_q + COUNT_WIDTH'(1);
    else                             count_d = count_q;
    if (count_clr_i)                  err_d = 1'b0;
    else if (dir_push_s && enc_s[32]) err_d = 1'b1;
    else                              err_d = err_q;
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      mode_q   <= 1'b0;
      active_q <= 1'b0;
      lfsr_q   <= SEED_C;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      mode_q   <= mode_i;
      active_q <= 1'b1;
      lfsr_q   <= lfsr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // FIFO storage; contents are only visible while occupancy is non-zero.
  always_ff @(posedge clk) begin
    if (push_s && !mode_chg_s) mem_q[wr_ptr_q] <= push_data_s;
  end

endmodule
